// File: rtl/simon_pkg.sv
// Shared Simon Says types and constants used by the sequence player,
// the compare path and the game controller.
package simon_pkg;

  typedef logic [1:0] sym_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LATCH  = 3'd2,
    ST_SHOW   = 3'd3,
    ST_GAP    = 3'd4,
    ST_FINISH = 3'd5
  } player_state_t;

  localparam logic [3:0] LED_BLANK          = 4'b0000;
  localparam int         DEFAULT_SEQ_MAX_LEN = 32;
  localparam int         DEFAULT_ON_CYCLES   = 4;
  localparam int         DEFAULT_OFF_CYCLES  = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/decoder_2_4.sv
// Symbol-to-LED one-hot map; shared with the compare path so the
// displayed and checked encodings stay identical.
module decoder_2_4
  import simon_pkg::*;
(
  input  sym_t       sym_i,
  output logic [3:0] led_o
);

  // combinational 2-to-4 one-hot decode
  always_comb begin
    led_o = LED_BLANK;
    case (sym_i)
      2'd0:    led_o = 4'b0001;
      2'd1:    led_o = 4'b0010;
      2'd2:    led_o = 4'b0100;
      2'd3:    led_o = 4'b1000;
      default: led_o = LED_BLANK;
    endcase
  end

endmodule

// File: rtl/seq_player.sv
// Plays the stored Simon sequence: fetches each symbol from a sync-read RAM,
// lights its LED for ON_CYCLES, blanks for OFF_CYCLES, then pulses done.
module seq_player
  import simon_pkg::*;
#(
  parameter int SEQ_MAX_LEN = DEFAULT_SEQ_MAX_LEN,
  parameter int ADDR_W      = $clog2(SEQ_MAX_LEN),
  parameter int ON_CYCLES   = DEFAULT_ON_CYCLES,
  parameter int OFF_CYCLES  = DEFAULT_OFF_CYCLES
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              on_off_i,
  input  logic              start_i,
  input  logic [ADDR_W:0]   seq_len_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  sym_t              mem_data_i,
  output logic [3:0]        led_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int                TICK_W   = $clog2(max_int(ON_CYCLES, OFF_CYCLES) + 1);
  localparam logic [TICK_W-1:0] ON_LAST  = TICK_W'(ON_CYCLES - 1);
  localparam logic [TICK_W-1:0] OFF_LAST = TICK_W'(OFF_CYCLES - 1);
  localparam logic [ADDR_W:0]   LEN_MAX  = (ADDR_W + 1)'(SEQ_MAX_LEN);

  player_state_t     state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  sym_t              cur_sym_q, cur_sym_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        led_q, led_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [3:0]        dec_led;

  // decode the symbol that will be shown next cycle so led can be registered
  decoder_2_4 u_decoder (
    .sym_i (cur_sym_d),
    .led_o (dec_led)
  );

  // next-state, counters and registered-output decode
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    tick_d     = tick_q;
    cur_sym_d  = cur_sym_q;
    mem_addr_d = mem_addr_q;

    if (!on_off_i) begin
      state_d = ST_IDLE;
      tick_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            len_d  = (seq_len_i > LEN_MAX) ? LEN_MAX : seq_len_i;
            idx_d  = '0;
            tick_d = '0;
            if (len_d == '0) begin
              state_d = ST_FINISH;
            end else begin
              state_d    = ST_FETCH;
              mem_addr_d = '0;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_FETCH: state_d = ST_LATCH;
        ST_LATCH: begin
          cur_sym_d = mem_data_i;
          tick_d    = '0;
          state_d   = ST_SHOW;
        end
        ST_SHOW: begin
          if (tick_q == ON_LAST) begin
            tick_d  = '0;
            state_d = ST_GAP;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        ST_GAP: begin
          if (tick_q == OFF_LAST) begin
            tick_d = '0;
            // the last index ends playback, so idx never wraps past len-1
            if ({1'b0, idx_q} == len_q - (ADDR_W + 1)'(1)) begin
              state_d = ST_FINISH;
            end else begin
              idx_d      = idx_q + ADDR_W'(1);
              mem_addr_d = idx_q + ADDR_W'(1);
              state_d    = ST_FETCH;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        ST_FINISH: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end

    led_d  = (state_d == ST_SHOW) ? dec_led : LED_BLANK;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FINISH);
  end

  // state and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      len_q      <= '0;
      tick_q     <= '0;
      cur_sym_q  <= 2'b00;
      mem_addr_q <= '0;
      led_q      <= LED_BLANK;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      tick_q     <= tick_d;
      cur_sym_q  <= cur_sym_d;
      mem_addr_q <= mem_addr_d;
      led_q      <= led_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign mem_addr_o = mem_addr_q;
  assign led_o      = led_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_seq_player.sv
// Randomized bench for seq_player against a trace model built from the
// playback timing rules (per-symbol fetch/latch/on/off, then one finish cycle).
module tb_seq_player;

  localparam int SEQ_MAX_LEN = 32;
  localparam int ADDR_W      = 5;
  localparam int ON_CYC      = 4;
  localparam int OFF_CYC     = 2;

  logic              clk = 1'b0;
  logic              reset, on_off, start;
  logic [ADDR_W:0]   seq_len;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_data;
  logic [3:0]        led;
  logic              busy, done;
  logic [1:0]        ram [SEQ_MAX_LEN];

  typedef struct {
    logic [3:0]        led;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] addr;
  } exp_t;

  exp_t              exp_q[$];
  logic [ADDR_W-1:0] exp_addr = '0;
  int                n_checks = 0;
  int                n_errors = 0;
  bit                chk_en = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= ram[mem_addr];

  seq_player #(
    .SEQ_MAX_LEN (SEQ_MAX_LEN),
    .ADDR_W      (ADDR_W),
    .ON_CYCLES   (ON_CYC),
    .OFF_CYCLES  (OFF_CYC)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .on_off_i   (on_off),
    .start_i    (start),
    .seq_len_i  (seq_len),
    .mem_addr_o (mem_addr),
    .mem_data_i (mem_data),
    .led_o      (led),
    .busy_o     (busy),
    .done_o     (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // expected per-cycle outputs for one accepted playback, starting the cycle after the start edge
  task automatic build_trace(input int req_len);
    int len;
    len = (req_len > SEQ_MAX_LEN) ? SEQ_MAX_LEN : req_len;
    if (len == 0) begin
      exp_q.push_back('{4'b0000, 1'b1, 1'b1, exp_addr});
    end else begin
      for (int i = 0; i < len; i++) begin
        exp_q.push_back('{4'b0000, 1'b1, 1'b0, ADDR_W'(i)});
        exp_q.push_back('{4'b0000, 1'b1, 1'b0, ADDR_W'(i)});
        for (int k = 0; k < ON_CYC; k++)
          exp_q.push_back('{4'b0001 << ram[i], 1'b1, 1'b0, ADDR_W'(i)});
        for (int k = 0; k < OFF_CYC; k++)
          exp_q.push_back('{4'b0000, 1'b1, 1'b0, ADDR_W'(i)});
      end
      exp_q.push_back('{4'b0000, 1'b1, 1'b1, ADDR_W'(len - 1)});
    end
  endtask

  // check the current cycle, then drive inputs and predict the next edge
  task automatic cycle(input logic r, input logic o, input logic s, input int l);
    exp_t e;
    bit   idle;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      idle = 1'b1;
      e    = '{4'b0000, 1'b0, 1'b0, exp_addr};
    end else begin
      idle     = 1'b0;
      e        = exp_q.pop_front();
      exp_addr = e.addr;
    end
    if (chk_en) begin
      check_eq("led",  32'(led),      32'(e.led));
      check_eq("busy", 32'(busy),     32'(e.busy));
      check_eq("done", 32'(done),     32'(e.done));
      check_eq("addr", 32'(mem_addr), 32'(e.addr));
    end
    reset   = r;
    on_off  = o;
    start   = s;
    seq_len = (ADDR_W + 1)'(l);
    if (r) begin
      exp_q.delete();
      exp_addr = '0;
    end else if (!o) begin
      exp_q.delete();
    end else if (s && idle) begin
      build_trace(l);
    end
  endtask

  task automatic run_to_idle(input bit noisy);
    for (int k = 0; k < 600 && exp_q.size() != 0; k++) begin
      if (noisy)
        cycle(1'b0, ($urandom_range(0, 199) != 0), 1'(($urandom_range(0, 7) == 0)),
              int'($urandom_range(0, 40)));
      else
        cycle(1'b0, 1'b1, 1'b0, 0);
    end
    cycle(1'b0, 1'b1, 1'b0, 0);
    cycle(1'b0, 1'b1, 1'b0, 0);
  endtask

  initial begin
    reset = 1'b1; on_off = 1'b0; start = 1'b0; seq_len = '0;
    for (int i = 0; i < SEQ_MAX_LEN; i++) ram[i] = 2'(i % 4);
    cycle(1'b1, 1'b0, 1'b0, 0);
    cycle(1'b1, 1'b0, 1'b0, 0);
    chk_en = 1'b1;
    cycle(1'b1, 1'b1, 1'b0, 0);
    cycle(1'b0, 1'b1, 1'b0, 0);
    cycle(1'b0, 1'b1, 1'b0, 0);

    // three-symbol playback {2,0,3}
    ram[0] = 2'd2; ram[1] = 2'd0; ram[2] = 2'd3;
    cycle(1'b0, 1'b1, 1'b1, 3);
    run_to_idle(1'b0);

    // zero length: finish immediately with no read
    cycle(1'b0, 1'b1, 1'b1, 0);
    run_to_idle(1'b0);

    // start with power off is ignored
    cycle(1'b0, 1'b0, 1'b1, 3);
    cycle(1'b0, 1'b1, 1'b0, 0);
    cycle(1'b0, 1'b1, 1'b0, 0);

    // full length, RAM[i] = i % 4
    for (int i = 0; i < SEQ_MAX_LEN; i++) ram[i] = 2'(i % 4);
    cycle(1'b0, 1'b1, 1'b1, SEQ_MAX_LEN);
    run_to_idle(1'b0);

    // abort during the second symbol's on-time
    cycle(1'b0, 1'b1, 1'b1, 5);
    repeat (11) cycle(1'b0, 1'b1, 1'b0, 0);
    cycle(1'b0, 1'b0, 1'b0, 0);
    repeat (4) cycle(1'b0, 1'b1, 1'b0, 0);

    // reset held three cycles mid-show
    cycle(1'b0, 1'b1, 1'b1, 4);
    repeat (4) cycle(1'b0, 1'b1, 1'b0, 0);
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 4);
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 0);

    // start pulses and seq_len changes while busy
    cycle(1'b0, 1'b1, 1'b1, 6);
    repeat (40) cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 32)));
    run_to_idle(1'b0);

    // random contents, lengths (including above max) and noise
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < SEQ_MAX_LEN; i++) ram[i] = 2'($urandom_range(0, 3));
      cycle(1'b0, 1'b1, 1'b1, int'($urandom_range(0, 40)));
      run_to_idle(1'b1);
      cycle(1'b0, 1'b1, 1'b0, 0);
      run_to_idle(1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
